// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage feeding execute through a two-entry skid buffer.
// Defining DECODE_STAGE_M_EXT_EN adds M-extension decode on OPREG/OP32 with funct7=0000001.
package cpu_pkg;
    localparam int unsigned ALU_CODE_W = 5;
    localparam int unsigned LDST_W     = 3;
    localparam int unsigned REG_IDX_W  = 5;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL    = 5'd2,
                                      ALU_SLT  = 5'd3,  ALU_SLTU = 5'd4,  ALU_XOR    = 5'd5,
                                      ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,  ALU_OR     = 5'd8,
                                      ALU_AND  = 5'd9,  ALU_LUI  = 5'd10, ALU_BEQ    = 5'd11,
                                      ALU_BNE  = 5'd12, ALU_BLT  = 5'd13, ALU_BGE    = 5'd14,
                                      ALU_BLTU = 5'd15, ALU_BGEU = 5'd16, ALU_MUL    = 5'd17,
                                      ALU_MULH = 5'd18, ALU_MULHSU = 5'd19, ALU_MULHU = 5'd20,
                                      ALU_DIV  = 5'd21, ALU_DIVU = 5'd22, ALU_REM    = 5'd23,
                                      ALU_REMU = 5'd24;

    localparam logic ALU_OP1_RS1 = 1'b0, ALU_OP1_PC  = 1'b1;
    localparam logic ALU_OP2_RS2 = 1'b0, ALU_OP2_IMM = 1'b1;
    localparam logic DISABLE     = 1'b0, ENABLE      = 1'b1;

    localparam logic [LDST_W-1:0] LOAD_DISABLE = 3'd0, LOAD_LB  = 3'd1, LOAD_LH  = 3'd2,
                                  LOAD_LW      = 3'd3, LOAD_LBU = 3'd4, LOAD_LHU = 3'd5,
                                  LOAD_LD      = 3'd6, LOAD_LWU = 3'd7;
    localparam logic [LDST_W-1:0] STORE_DISABLE = 3'd0, STORE_SB = 3'd1, STORE_SH = 3'd2,
                                  STORE_SW      = 3'd3, STORE_SD = 3'd4;

    localparam logic [6:0] OPC_OPIMM  = 7'h13, OPC_OPIMM32 = 7'h1B, OPC_OPREG = 7'h33,
                           OPC_OP32   = 7'h3B, OPC_LUI     = 7'h37, OPC_AUIPC = 7'h17,
                           OPC_LOAD   = 7'h03, OPC_STORE   = 7'h23, OPC_BRANCH = 7'h63,
                           OPC_JAL    = 7'h6F, OPC_JALR    = 7'h67;

    typedef struct packed {
        logic [ALU_CODE_W-1:0] alu_code;
        logic                  alu_op1_sel;
        logic                  alu_op2_sel;
        logic                  reg_we;
        logic [LDST_W-1:0]     is_load;
        logic [LDST_W-1:0]     is_store;
        logic                  is_word;
        logic [REG_IDX_W-1:0]  rd;
        logic [REG_IDX_W-1:0]  rs1;
        logic [REG_IDX_W-1:0]  rs2;
        logic                  illegal;
    } dec_ctrl_t;
endpackage

module decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_insn,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_imm,
    output logic [ALU_CODE_W-1:0] out_alu_code,
    output logic                  out_alu_op1_sel,
    output logic                  out_alu_op2_sel,
    output logic                  out_reg_we,
    output logic [LDST_W-1:0]     out_is_load,
    output logic [LDST_W-1:0]     out_is_store,
    output logic                  out_is_word,
    output logic [REG_IDX_W-1:0]  out_rd,
    output logic [REG_IDX_W-1:0]  out_rs1,
    output logic [REG_IDX_W-1:0]  out_rs2,
    output logic                  out_illegal
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end

    localparam bit IS_RV64 = (XLEN == 64);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_insn[6:0];
    assign funct3 = in_insn[14:12];
    assign funct7 = in_insn[31:25];
    assign imm_i  = {{20{in_insn[31]}}, in_insn[31:20]};
    assign imm_s  = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    assign imm_b  = {{20{in_insn[31]}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
    assign imm_u  = {in_insn[31:12], 12'b0};
    assign imm_j  = {{12{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};

    function automatic logic [ALU_CODE_W-1:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Register-register ALU selection shared by OPREG and OP32
    logic [ALU_CODE_W-1:0] rr_alu_c;
    logic                  rr_bad_c;

    always_comb begin
        rr_alu_c = ALU_ADD;
        rr_bad_c = 1'b0;
        case (funct7)
            7'b0000000: rr_alu_c = base_alu(funct3, 1'b0);
            7'b0100000: begin
                if (funct3 == 3'b000)      rr_alu_c = ALU_SUB;
                else if (funct3 == 3'b101) rr_alu_c = ALU_SRA;
                else                       rr_bad_c = 1'b1;
            end
`ifdef DECODE_STAGE_M_EXT_EN
            7'b0000001: rr_alu_c = ALU_MUL + ALU_CODE_W'(funct3);
`endif
            default:    rr_bad_c = 1'b1;
        endcase
    end

    dec_ctrl_t   dec_c;
    logic [31:0] imm32_c;
    logic        bad_c;

    always_comb begin
        dec_c     = '0;
        imm32_c   = '0;
        bad_c     = 1'b0;
        dec_c.rd  = in_insn[11:7];
        dec_c.rs1 = in_insn[19:15];
        dec_c.rs2 = in_insn[24:20];
        case (opcode)
            OPC_OPIMM: begin
                imm32_c           = imm_i;
                dec_c.alu_op2_sel = ALU_OP2_IMM;
                dec_c.reg_we      = ENABLE;
                dec_c.alu_code    = base_alu(funct3, in_insn[30]);
                bad_c             = !IS_RV64 && (funct3[1:0] == 2'b01) && in_insn[25];
            end
            OPC_OPIMM32: begin
                if (IS_RV64) begin
                    imm32_c           = imm_i;
                    dec_c.alu_op2_sel = ALU_OP2_IMM;
                    dec_c.reg_we      = ENABLE;
                    dec_c.is_word     = 1'b1;
                    case (funct3)
                        3'b001:  dec_c.alu_code = ALU_SLL;
                        3'b101:  dec_c.alu_code = in_insn[30] ? ALU_SRA : ALU_SRL;
                        default: dec_c.alu_code = ALU_ADD;
                    endcase
                end else begin
                    bad_c = 1'b1;
                end
            end
            OPC_OPREG: begin
                dec_c.reg_we   = ENABLE;
                dec_c.alu_code = rr_alu_c;
                bad_c          = rr_bad_c;
            end
            OPC_OP32: begin
                if (IS_RV64) begin
                    dec_c.reg_we   = ENABLE;
                    dec_c.is_word  = 1'b1;
                    dec_c.alu_code = rr_alu_c;
                    bad_c          = rr_bad_c;
                end else begin
                    bad_c = 1'b1;
                end
            end
            OPC_LUI: begin
                imm32_c           = imm_u;
                dec_c.alu_op2_sel = ALU_OP2_IMM;
                dec_c.reg_we      = ENABLE;
                dec_c.alu_code    = ALU_LUI;
            end
            OPC_AUIPC, OPC_JAL: begin
                imm32_c           = (opcode == OPC_JAL) ? imm_j : imm_u;
                dec_c.alu_op1_sel = ALU_OP1_PC;
                dec_c.alu_op2_sel = ALU_OP2_IMM;
                dec_c.reg_we      = ENABLE;
            end
            OPC_JALR: begin
                imm32_c           = imm_i;
                dec_c.alu_op2_sel = ALU_OP2_IMM;
                dec_c.reg_we      = ENABLE;
            end
            OPC_LOAD: begin
                imm32_c           = imm_i;
                dec_c.alu_op2_sel = ALU_OP2_IMM;
                dec_c.reg_we      = ENABLE;
                case (funct3)
                    3'b000:  dec_c.is_load = LOAD_LB;
                    3'b001:  dec_c.is_load = LOAD_LH;
                    3'b010:  dec_c.is_load = LOAD_LW;
                    3'b011:  begin dec_c.is_load = LOAD_LD;  bad_c = !IS_RV64; end
                    3'b100:  dec_c.is_load = LOAD_LBU;
                    3'b101:  dec_c.is_load = LOAD_LHU;
                    3'b110:  begin dec_c.is_load = LOAD_LWU; bad_c = !IS_RV64; end
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm32_c           = imm_s;
                dec_c.alu_op2_sel = ALU_OP2_IMM;
                case (funct3)
                    3'b000:  dec_c.is_store = STORE_SB;
                    3'b001:  dec_c.is_store = STORE_SH;
                    3'b010:  dec_c.is_store = STORE_SW;
                    3'b011:  begin dec_c.is_store = STORE_SD; bad_c = !IS_RV64; end
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                imm32_c = imm_b;
                case (funct3)
                    3'b000:  dec_c.alu_code = ALU_BEQ;
                    3'b001:  dec_c.alu_code = ALU_BNE;
                    3'b100:  dec_c.alu_code = ALU_BLT;
                    3'b101:  dec_c.alu_code = ALU_BGE;
                    3'b110:  dec_c.alu_code = ALU_BLTU;
                    3'b111:  dec_c.alu_code = ALU_BGEU;
                    default: bad_c = 1'b1;
                endcase
            end
            default: bad_c = 1'b1;
        endcase
        // Illegal entries still flow downstream but must have no architectural side effect
        if (bad_c) begin
            dec_c.reg_we   = DISABLE;
            dec_c.is_load  = LOAD_DISABLE;
            dec_c.is_store = STORE_DISABLE;
            dec_c.alu_code = ALU_ADD;
        end
        dec_c.illegal = bad_c;
    end

    state_t          state, state_n;
    logic            accept_c, load_main_c, load_skid_c, skid_to_main_c;
    dec_ctrl_t       main_ctrl, skid_ctrl;
    logic [XLEN-1:0] main_pc, main_imm, skid_pc, skid_imm, dec_imm_c;

    assign dec_imm_c = XLEN'($signed(imm32_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n != TWO);
            out_valid <= (state_n != EMPTY);
        end
    end

    always_comb begin
        state_n        = state;
        load_main_c    = 1'b0;
        load_skid_c    = 1'b0;
        skid_to_main_c = 1'b0;
        accept_c       = in_valid && in_ready && !flush;
        case (state)
            EMPTY: if (accept_c) begin
                state_n     = ONE;
                load_main_c = 1'b1;
            end
            ONE: begin
                if (accept_c && out_ready) begin
                    load_main_c = 1'b1;
                end else if (accept_c) begin
                    state_n     = TWO;
                    load_skid_c = 1'b1;
                end else if (out_ready) begin
                    state_n = EMPTY;
                end
            end
            TWO: if (out_ready) begin
                state_n        = ONE;
                skid_to_main_c = 1'b1;
            end
            default: state_n = EMPTY;
        endcase
        if (flush) begin
            state_n        = EMPTY;
            skid_to_main_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl <= '0;
            main_pc   <= '0;
            main_imm  <= '0;
            skid_ctrl <= '0;
            skid_pc   <= '0;
            skid_imm  <= '0;
        end else begin
            if (load_main_c) begin
                main_ctrl <= dec_c;
                main_pc   <= in_pc;
                main_imm  <= dec_imm_c;
            end else if (skid_to_main_c) begin
                main_ctrl <= skid_ctrl;
                main_pc   <= skid_pc;
                main_imm  <= skid_imm;
            end
            if (load_skid_c) begin
                skid_ctrl <= dec_c;
                skid_pc   <= in_pc;
                skid_imm  <= dec_imm_c;
            end
        end
    end

    assign out_pc          = main_pc;
    assign out_imm         = main_imm;
    assign out_alu_code    = main_ctrl.alu_code;
    assign out_alu_op1_sel = main_ctrl.alu_op1_sel;
    assign out_alu_op2_sel = main_ctrl.alu_op2_sel;
    assign out_reg_we      = main_ctrl.reg_we;
    assign out_is_load     = main_ctrl.is_load;
    assign out_is_store    = main_ctrl.is_store;
    assign out_is_word     = main_ctrl.is_word;
    assign out_rd          = main_ctrl.rd;
    assign out_rs1         = main_ctrl.rs1;
    assign out_rs2         = main_ctrl.rs2;
    assign out_illegal     = main_ctrl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 and an RV64 instance share one stimulus stream.
module tb_decode_stage;
    import cpu_pkg::*;

`ifdef DECODE_STAGE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  alu;
        logic        op1;
        logic        op2;
        logic        we;
        logic [2:0]  ld;
        logic [2:0]  st;
        logic        word;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_insn;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_op1, a_op2, a_we, a_word, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_alu, a_rd, a_rs1, a_rs2;
    logic [2:0]  a_ld, a_st;
    logic        b_in_ready, b_out_valid, b_op1, b_op2, b_we, b_word, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_alu, b_rd, b_rs1, b_rs2;
    logic [2:0]  b_ld, b_st;

    int   total = 0;
    int   bad   = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_insn(in_insn), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_imm(a_imm), .out_alu_code(a_alu), .out_alu_op1_sel(a_op1),
        .out_alu_op2_sel(a_op2), .out_reg_we(a_we), .out_is_load(a_ld), .out_is_store(a_st),
        .out_is_word(a_word), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_illegal(a_ill)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_imm(b_imm), .out_alu_code(b_alu), .out_alu_op1_sel(b_op1),
        .out_alu_op2_sel(b_op2), .out_reg_we(b_we), .out_is_load(b_ld), .out_is_store(b_st),
        .out_is_word(b_word), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_illegal(b_ill)
    );

    // Reference decode computed from the ISA rules with lookup tables
    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [63:0] pc, input bit x64);
        exp_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rr_tab [8];
        logic [4:0] br_tab [8];
        logic [2:0] ld_tab [8];
        logic [2:0] st_tab [4];
        logic [63:0] ii, ims, ib, iu, ij;
        rr_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br_tab = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        ld_tab = '{LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LD, LOAD_LBU, LOAD_LHU, LOAD_LWU, LOAD_DISABLE};
        st_tab = '{STORE_SB, STORE_SH, STORE_SW, STORE_SD};
        opc = insn[6:0];
        f3  = insn[14:12];
        f7  = insn[31:25];
        ii  = 64'($signed(insn[31:20]));
        ims = 64'($signed({insn[31:25], insn[11:7]}));
        ib  = 64'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
        iu  = 64'($signed({insn[31:12], 12'b0}));
        ij  = 64'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
        e     = '0;
        e.pc  = pc;
        e.rd  = insn[11:7];
        e.rs1 = insn[19:15];
        e.rs2 = insn[24:20];
        case (opc)
            7'h13: begin
                e.imm = ii; e.op2 = 1'b1; e.we = 1'b1;
                e.alu = (f3 == 3'd5 && insn[30]) ? ALU_SRA : rr_tab[f3];
                if (!x64 && (f3 == 3'd1 || f3 == 3'd5) && insn[25]) e.ill = 1'b1;
            end
            7'h1B: begin
                if (!x64) e.ill = 1'b1;
                else begin
                    e.imm = ii; e.op2 = 1'b1; e.we = 1'b1; e.word = 1'b1;
                    e.alu = (f3 == 3'd1) ? ALU_SLL : (f3 == 3'd5) ? (insn[30] ? ALU_SRA : ALU_SRL) : ALU_ADD;
                end
            end
            7'h33, 7'h3B: begin
                if (opc == 7'h3B && !x64) e.ill = 1'b1;
                else begin
                    e.we = 1'b1; e.word = (opc == 7'h3B);
                    if (f7 == 7'h00) e.alu = rr_tab[f3];
                    else if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALU_SUB;
                    else if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALU_SRA;
                    else if (f7 == 7'h01 && M_EN) e.alu = 5'(ALU_MUL + 5'(f3));
                    else e.ill = 1'b1;
                end
            end
            7'h37: begin e.imm = iu; e.op2 = 1'b1; e.we = 1'b1; e.alu = ALU_LUI; end
            7'h17: begin e.imm = iu; e.op1 = 1'b1; e.op2 = 1'b1; e.we = 1'b1; end
            7'h6F: begin e.imm = ij; e.op1 = 1'b1; e.op2 = 1'b1; e.we = 1'b1; end
            7'h67: begin e.imm = ii; e.op2 = 1'b1; e.we = 1'b1; end
            7'h03: begin
                e.imm = ii; e.op2 = 1'b1; e.we = 1'b1; e.ld = ld_tab[f3];
                if (f3 == 3'd7 || (!x64 && (f3 == 3'd3 || f3 == 3'd6))) e.ill = 1'b1;
            end
            7'h23: begin
                e.imm = ims; e.op2 = 1'b1;
                if (f3 >= 3'd4 || (!x64 && f3 == 3'd3)) e.ill = 1'b1;
                else e.st = st_tab[f3[1:0]];
            end
            7'h63: begin
                e.imm = ib; e.alu = br_tab[f3];
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.we = 1'b0; e.ld = LOAD_DISABLE; e.st = STORE_DISABLE; e.alu = ALU_ADD;
        end
        if (!x64) e.imm[63:32] = 32'b0;
        return e;
    endfunction

    function automatic exp_t act32();
        exp_t a;
        a = '{pc: {32'b0, a_pc}, imm: {32'b0, a_imm}, alu: a_alu, op1: a_op1, op2: a_op2, we: a_we,
              ld: a_ld, st: a_st, word: a_word, rd: a_rd, rs1: a_rs1, rs2: a_rs2, ill: a_ill};
        return a;
    endfunction

    function automatic exp_t act64();
        exp_t a;
        a = '{pc: b_pc, imm: b_imm, alu: b_alu, op1: b_op1, op2: b_op2, we: b_we,
              ld: b_ld, st: b_st, word: b_word, rd: b_rd, rs1: b_rs1, rs2: b_rs2, ill: b_ill};
        return a;
    endfunction

    task automatic check_entry(input string name, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor + scoreboard: occupancy, pops on transfer, pushes on acceptance, clears on flush/rst
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            q64.delete();
        end else begin
            check_bit("occ32_out_valid", a_out_valid, q32.size() > 0);
            check_bit("occ32_in_ready",  a_in_ready,  q32.size() < 2);
            check_bit("occ64_out_valid", b_out_valid, q64.size() > 0);
            check_bit("occ64_in_ready",  b_in_ready,  q64.size() < 2);
            if (a_out_valid && out_ready && q32.size() > 0) check_entry("entry32", act32(), q32.pop_front());
            if (b_out_valid && out_ready && q64.size() > 0) check_entry("entry64", act64(), q64.pop_front());
            if (in_valid && !flush) begin
                if (a_in_ready) q32.push_back(ref_decode(in_insn, {32'b0, in_pc[31:0]}, 1'b0));
                if (b_in_ready) q64.push_back(ref_decode(in_insn, in_pc, 1'b1));
            end
            if (flush) begin
                q32.delete();
                q64.delete();
            end
        end
    end

    task automatic send(input logic [31:0] insn, input logic [63:0] pc);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_insn  = insn;
        in_pc    = pc;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = b_in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=in_ready_low required=accept insn=%h", insn);
        end
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  opcs [13];
        logic [31:0] w;
        opcs = '{7'h13, 7'h1B, 7'h33, 7'h3B, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h0F};
        w = $urandom();
        w[6:0] = opcs[$urandom_range(12, 0)];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h3B) begin
            case ($urandom_range(3, 0))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_insn = 32'b0; in_pc = 64'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_entry("reset32", act32(), '0);
        check_entry("reset64", act64(), '0);
        @(posedge clk);
        #1;

        // Directed instructions streamed with out_ready high
        out_ready = 1'b1;
        send(32'h00500093, 64'h1000);
        send(32'h80000137, 64'hFFFF_FFFF_8000_1004);
        send(32'h00813183, 64'h1008);
        send(32'h027302B3, 64'h100C);
        send(32'h0000007F, 64'h1010);
        send(32'h00002063, 64'h1014);
        send(32'h0000A023, 64'h1018);
        send(32'h0010509B, 64'h101C);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two fill the buffer, the third waits until execute drains
        out_ready = 1'b0;
        send(32'h00100113, 64'h2000);
        send(32'h402081B3, 64'h2004);
        in_insn = 32'hFFF00213;
        in_pc   = 64'h2008;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'hFFF00213, 64'h2008);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Flush with the buffer full and a beat on the input
        out_ready = 1'b0;
        send(32'h00300293, 64'h3000);
        send(32'h00400313, 64'h3004);
        in_insn = 32'h00500393;
        in_pc   = 64'h3008;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("flush_out_valid", b_out_valid, 1'b0);
        check_bit("flush_in_ready",  b_in_ready,  1'b1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with occasional flush and one mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom() % 4) != 0;
            out_ready = ($urandom() % 3) != 0;
            flush     = ($urandom() % 60) == 0;
            rst       = (i == 1500);
            in_insn   = rand_insn();
            in_pc     = {$urandom(), $urandom()} & ~64'h3;
            @(posedge clk);
            #1;
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (q32.size() != 0 || q64.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d/%0d required=0/0", q32.size(), q64.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage for the pipelined core, sitting between fetch and execute. Accepts one instruction plus PC per cycle over a valid/ready handshake, decodes it into the cpu_pkg control fields (imm, alu_code, operand selects, write enable, load/store kind, register indices) and holds them in a two-entry skid buffer, so every output and `in_ready` is driven from a flop. Adds XLEN generalisation, illegal-instruction detection, flush, and optional M-extension decode.

## Interface
- XLEN, 32: datapath width, 32 or 64; any other value is an elaboration error.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop all buffered entries; input beat on the same cycle is also dropped.
- in_valid  in  1  fetch presents insn/pc.
- in_ready  out  1  stage can accept; registered.
- in_insn  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  execute accepts the entry.
- out_pc  out  XLEN  pc of the entry.
- out_imm  out  XLEN  immediate, sign-extended to XLEN (U-type: insn[31:12]<<12, sign-extended).
- out_alu_code  out  5  cpu_pkg ALU_* code.
- out_alu_op1_sel, out_alu_op2_sel  out  1 each  ALU_OP1_RS1/PC, ALU_OP2_RS2/IMM.
- out_reg_we  out  1  ENABLE/DISABLE.
- out_is_load  out  3  LOAD_DISABLE/LB/LH/LW/LBU/LHU/LD/LWU.
- out_is_store  out  3  STORE_DISABLE/SB/SH/SW/SD.
- out_is_word  out  1  RV64 *W op (OP-IMM-32/OP-32); always 0 when XLEN=32.
- out_rd, out_rs1, out_rs2  out  5 each  insn[11:7], [19:15], [24:20].
- out_illegal  out  1  instruction not decodable.

## Operation
- Decode is combinational on `in_insn`, captured on acceptance (`in_valid && in_ready`); opcode classes OPIMM, OPREG, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, plus OPIMM32/OP32 when XLEN=64.
- Operand selects: JALR is RS1+IMM (target = rs1+imm); AUIPC and JAL are PC+IMM; OPIMM/LUI/LOAD/STORE RS1+IMM; OPREG/BRANCH RS1+RS2.
- reg_we = ENABLE for OPIMM, OPREG, LUI, AUIPC, LOAD, JAL, JALR, OPIMM32, OP32, and only if not illegal.
- Illegal when: unknown opcode; BRANCH funct3 010/011; LOAD funct3 111, or 011/110 with XLEN=32; STORE funct3 >= 100, or 011 with XLEN=32; OPREG funct7 not 0000000/0100000 (0100000 valid only for funct3 000/101); shift imm with shamt[5] set when XLEN=32. Illegal entries force reg_we=DISABLE, is_load/is_store=*_DISABLE, alu_code=ALU_ADD, and still flow downstream.
- Skid buffer: entries `main` (drives outputs) and `skid`. States EMPTY (0 entries), ONE, TWO.
  - EMPTY: accept -> ONE.
  - ONE: accept & !out_ready -> TWO (into skid); !accept & out_ready -> EMPTY; accept & out_ready -> ONE (main replaced).
  - TWO: out_ready -> ONE (skid moves to main); no accept possible.
- in_ready = (state != TWO), registered.
- flush overrides all: next state EMPTY, in_ready=1 next cycle.

## Timing
- Latency: accepted beat appears on out_* the next cycle (1 cycle) when EMPTY or draining.
- Throughput: 1 insn/cycle with out_ready held high.
- Outputs stable while out_valid && !out_ready; order strictly FIFO.
- Reset: state EMPTY, out_valid=0, in_ready=1 on the first cycle after rst; all out_* data fields 0, out_is_load=LOAD_DISABLE, out_is_store=STORE_DISABLE, out_illegal=0.
- rst mid-operation discards all entries as flush does; rst wins over flush.
- Data fields of an invalid output hold their last value (no requirement beyond reset).

## Configuration
- DECODE_STAGE_M_EXT_EN defined: OPREG (and OP32 when XLEN=64) with funct7=0000001 decodes to ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU by funct3 (cpu_pkg codes), reg_we=ENABLE.
- Undefined: funct7=0000001 sets out_illegal=1 per the illegal rule; no M codes are ever produced.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with out_ready=1 -> next cycle out_valid=1, imm=5, alu_code=ALU_ADD, op2_sel=IMM, reg_we=1, rd=1, illegal=0.
- XLEN=64: `lui x2,0x80000` (0x80000137) -> imm=0xFFFFFFFF80000000, alu_code=ALU_LUI; `ld x3,8(x2)` (0x00813183) -> is_load=LOAD_LD; same ld at XLEN=32 -> illegal=1, reg_we=0.
- Backpressure: 3 back-to-back beats, out_ready=0 -> in_ready falls after 2 accepted; out_ready=1 -> entries emerge in order, one per cycle, in_ready returns 1.
- flush while TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed entries and the concurrent beat never appear.
- `mul x5,x6,x7` (0x027302B3): with DECODE_STAGE_M_EXT_EN -> alu_code=ALU_MUL, reg_we=1; without -> illegal=1, reg_we=0.
- Opcode 0x7F and `beq` funct3 010 (0x00002063) -> illegal=1, is_store=STORE_DISABLE, reg_we=0.
